// File: rtl/nios_system_pio_plus_if.sv
// Avalon-MM slave bus bundle for the PIO peripheral: a 3-bit word address,
// an active-low write strobe and a zero-wait-state combinational read.
interface nios_system_pio_plus_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_pio_plus.sv
// Avalon-MM parallel I/O with atomic set/clear, self-timed pulse bits,
// a 2-flop input synchroniser and sticky edge capture driving a maskable irq.
module nios_system_pio_plus #(
    parameter int          OUT_WIDTH = 8,
    parameter int          IN_WIDTH  = 8,
    parameter int          EDGE_TYPE = 0,
    parameter int          PULSE_LEN = 16,
    parameter logic [31:0] OUT_RESET = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    nios_system_pio_plus_if.slave bus,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port,
    output logic                 irq
);
    localparam int CW = $clog2(PULSE_LEN + 1);

    logic [OUT_WIDTH-1:0] data_q, data_d, pmask_q, pmask_d, wd_out;
    logic [IN_WIDTH-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [IN_WIDTH-1:0]  cap_q, cap_d, mask_q, mask_d, wd_in, edges;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 wr, expire;

    assign wr     = bus.chipselect & ~bus.write_n;
    assign wd_out = bus.writedata[OUT_WIDTH-1:0];
    assign wd_in  = bus.writedata[IN_WIDTH-1:0];
    assign expire = (cnt_q == CW'(1));

    // Edge qualification selected at elaboration time
    always_comb begin
        edges = sync2_q ^ prev_q;
        if (EDGE_TYPE == 0)      edges = sync2_q & ~prev_q;
        else if (EDGE_TYPE == 1) edges = ~sync2_q & prev_q;
    end

    // Next-state: pulse expiry first, then bus writes override the bits they touch
    always_comb begin
        data_d  = data_q;
        pmask_d = pmask_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        cap_d   = cap_q | edges;
        sync1_d = in_port;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        if (expire) begin
            data_d  = data_q & ~pmask_q;
            pmask_d = '0;
        end
        if (wr) begin
            case (bus.address)
                3'd0: begin
                    data_d  = wd_out;
                    pmask_d = '0;
                    cnt_d   = '0;
                end
                3'd2: mask_d = wd_in;
                // new edges win over the write-1-clear
                3'd3: cap_d = (cap_q & ~wd_in) | edges;
                3'd4: begin
                    data_d  = data_d | wd_out;
                    pmask_d = pmask_d & ~wd_out;
                end
                3'd5: begin
                    data_d  = data_d & ~wd_out;
                    pmask_d = pmask_d & ~wd_out;
                end
                3'd6: if (wd_out != '0) begin
                    // old pulse bits merge into the new pulse, even at expiry
                    data_d  = data_q | wd_out;
                    pmask_d = pmask_q | wd_out;
                    cnt_d   = CW'(PULSE_LEN);
                end
                default: ;
            endcase
        end
    end

    // State registers; reset aborts any pulse in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= OUT_RESET[OUT_WIDTH-1:0];
            pmask_q <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            data_q  <= data_d;
            pmask_q <= pmask_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Zero-latency read mux, zero-extended
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0: bus.readdata[OUT_WIDTH-1:0] = data_q;
            3'd1: bus.readdata[IN_WIDTH-1:0]  = sync2_q;
            3'd2: bus.readdata[IN_WIDTH-1:0]  = mask_q;
            3'd3: bus.readdata[IN_WIDTH-1:0]  = cap_q;
            3'd6: bus.readdata[OUT_WIDTH-1:0] = pmask_q;
            default: ;
        endcase
    end

    assign out_port = data_q;
    assign irq      = |(cap_q & mask_q);
endmodule

// File: tb/tb_nios_system_pio_plus.sv
// Directed bench: two instances (rising-edge and any-edge capture) share
// stimulus; table-driven register vectors plus hand-timed pulse/edge sequences.
module tb_nios_system_pio_plus;
    logic       clk = 0;
    logic       reset = 1;
    logic [7:0] in_port = '0;
    logic [7:0] out0, out2;
    logic       irq0, irq2;
    int         tests = 0, errs = 0;
    logic [31:0] r0, r2;

    nios_system_pio_plus_if bus0();
    nios_system_pio_plus_if bus2();

    nios_system_pio_plus #(.OUT_WIDTH(8), .IN_WIDTH(8), .EDGE_TYPE(0), .PULSE_LEN(16),
                           .OUT_RESET(32'hA5)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .in_port(in_port),
        .out_port(out0), .irq(irq0));
    nios_system_pio_plus #(.OUT_WIDTH(8), .IN_WIDTH(8), .EDGE_TYPE(2), .PULSE_LEN(16),
                           .OUT_RESET(32'hA5)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave), .in_port(in_port),
        .out_port(out2), .irq(irq2));

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus0.chipselect = 0; bus0.write_n = 1;
        bus2.chipselect = 0; bus2.write_n = 1;
    endtask

    // write lands on the next rising edge; returns #1 after it
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus0.address = a; bus0.writedata = d; bus0.chipselect = 1; bus0.write_n = 0;
        bus2.address = a; bus2.writedata = d; bus2.chipselect = 1; bus2.write_n = 0;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v0, output logic [31:0] v2);
        @(negedge clk);
        bus0.address = a; bus0.chipselect = 1; bus0.write_n = 1;
        bus2.address = a; bus2.chipselect = 1; bus2.write_n = 1;
        #1;
        v0 = bus0.readdata; v2 = bus2.readdata;
        idle();
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1, 3'd0, 32'h0000_000F, 8'h0F, 32'h0};
        vecs[1]  = '{1, 3'd4, 32'h0000_0030, 8'h3F, 32'h0};
        vecs[2]  = '{1, 3'd5, 32'h0000_0003, 8'h3C, 32'h0};
        vecs[3]  = '{0, 3'd0, 32'h0,         8'h3C, 32'h3C};
        vecs[4]  = '{0, 3'd4, 32'h0,         8'h3C, 32'h0};
        vecs[5]  = '{0, 3'd5, 32'h0,         8'h3C, 32'h0};
        vecs[6]  = '{0, 3'd7, 32'h0,         8'h3C, 32'h0};
        vecs[7]  = '{1, 3'd7, 32'hFFFF_FFFF, 8'h3C, 32'h0};
        vecs[8]  = '{1, 3'd1, 32'hFFFF_FFFF, 8'h3C, 32'h0};
        vecs[9]  = '{0, 3'd1, 32'h0,         8'h3C, 32'h0};
        vecs[10] = '{1, 3'd0, 32'hFFFF_FF5A, 8'h5A, 32'h0};
        vecs[11] = '{0, 3'd0, 32'h0,         8'h5A, 32'h5A};
        vecs[12] = '{1, 3'd6, 32'h0,         8'h5A, 32'h0};
        vecs[13] = '{0, 3'd6, 32'h0,         8'h5A, 32'h0};

        idle();
        bus0.address = 0; bus0.writedata = 0;
        bus2.address = 0; bus2.writedata = 0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;
        chk("rst_out", {out2, out0}, 16'hA5A5);
        chk("rst_irq", {irq2, irq0}, 2'b00);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), r0, r2);
            chk($sformatf("rst_rd%0d", a), r0, (a == 0) ? 32'hA5 : 32'h0);
            chk($sformatf("rst_rd%0d_b", a), r2, (a == 0) ? 32'hA5 : 32'h0);
        end

        // register map vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, r0, r2);
                chk($sformatf("vec%0d_rd", i), r0, vecs[i].exp_rd);
            end
            chk($sformatf("vec%0d_out", i), {24'h0, out0}, {24'h0, vecs[i].exp_out});
        end

        // single pulse: high for exactly 16 cycles
        wr(3'd0, 32'h0);
        wr(3'd6, 32'h80);
        begin
            int bad = 0;
            for (int k = 1; k < 16; k++) begin
                @(posedge clk); #1;
                if (out0[7] !== 1'b1) bad++;
            end
            chk("pulse_high_span", bad, 0);
        end
        @(posedge clk); #1;
        chk("pulse_fall", {24'h0, out0}, 32'h0);
        rd(3'd6, r0, r2);
        chk("pulse_mask_clr", r0, 32'h0);

        // re-write at +10 extends to +26
        wr(3'd6, 32'h80);
        repeat (9) @(posedge clk); #1;
        wr(3'd6, 32'h80);
        repeat (15) @(posedge clk); #1;
        chk("extend_high", {31'h0, out0[7]}, 32'h1);
        @(posedge clk); #1;
        chk("extend_fall", {31'h0, out0[7]}, 32'h0);

        // OUTSET mid-pulse makes the bit permanent
        wr(3'd6, 32'h80);
        repeat (4) @(posedge clk); #1;
        wr(3'd4, 32'h80);
        repeat (15) @(posedge clk); #1;
        chk("outset_keep", {31'h0, out0[7]}, 32'h1);
        rd(3'd6, r0, r2);
        chk("outset_pmask", r0, 32'h0);

        // OUTSET in the expiry cycle
        wr(3'd0, 32'h0);
        wr(3'd6, 32'h03);
        repeat (15) @(posedge clk); #1;
        chk("exp_pre", {24'h0, out0}, 32'h03);
        wr(3'd4, 32'h01);
        chk("exp_collide", {24'h0, out0}, 32'h01);

        // PULSE re-write in the expiry cycle merges old bits
        wr(3'd0, 32'h0);
        wr(3'd6, 32'h01);
        repeat (15) @(posedge clk); #1;
        wr(3'd6, 32'h02);
        chk("exp_pulse_merge", {24'h0, out0}, 32'h03);
        rd(3'd6, r0, r2);
        chk("exp_pulse_pmask", r0, 32'h03);

        // reset mid-pulse
        wr(3'd0, 32'h0);
        wr(3'd6, 32'h40);
        repeat (3) @(posedge clk); #1;
        reset = 1; #1;
        chk("midrst_out", {out2, out0}, 16'hA5A5);
        rd(3'd6, r0, r2);
        chk("midrst_pmask", r0, 32'h0);
        @(negedge clk); reset = 0;

        // rising edge capture on bit0
        wr(3'd2, 32'h01);
        rd(3'd2, r0, r2);
        chk("irqmask_rd", r0, 32'h01);
        @(negedge clk); in_port = 8'h01;
        @(posedge clk); @(posedge clk);
        rd(3'd1, r0, r2);
        chk("in_sync", r0, 32'h01);
        chk("irq_before_e2", {31'h0, irq0}, 32'h0);
        rd(3'd3, r0, r2);
        chk("rise_cap", r0, 32'h01);
        chk("rise_cap_any", r2, 32'h01);
        chk("rise_irq", {irq2, irq0}, 2'b11);
        wr(3'd3, 32'h01);
        chk("clr_irq", {irq2, irq0}, 2'b00);

        // falling edge: only any-edge instance captures
        @(negedge clk); in_port = 8'h00;
        repeat (4) @(posedge clk);
        rd(3'd3, r0, r2);
        chk("fall_cap_rise", r0, 32'h0);
        chk("fall_cap_any", r2, 32'h01);
        chk("fall_irq", {irq2, irq0}, 2'b10);
        wr(3'd3, 32'hFF);

        // new edge on bit3 coincides with its write-1-clear
        wr(3'd2, 32'h09);
        @(negedge clk); in_port = 8'h08;
        @(posedge clk); @(posedge clk);
        wr(3'd3, 32'h08);
        rd(3'd3, r0, r2);
        chk("collide_cap", r0, 32'h08);
        chk("collide_cap_any", r2, 32'h08);
        chk("collide_irq", {irq2, irq0}, 2'b11);
        wr(3'd3, 32'h08);
        rd(3'd3, r0, r2);
        chk("plain_clr", r0, 32'h0);
        chk("plain_clr_irq", {31'h0, irq0}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule

// File: doc/nios_system_pio_plus.md
# nios_system_pio_plus

Parametrised Avalon-MM parallel I/O peripheral for the Nios II system. It provides an OUT_WIDTH-bit output port with atomic set/clear and self-timed pulse bits, and an IN_WIDTH-bit input port with a 2-flop synchroniser. Input edges are captured into sticky per-bit flags that drive a maskable interrupt. It sits on the system interconnect beside the existing output PIOs and replaces them where software needs read-modify-write-free bit control or input events.

## Interface
- OUT_WIDTH, 8: output port width, 1..32.
- IN_WIDTH, 8: input port width, 1..32.
- EDGE_TYPE, 0: edge capture mode. 0 = rising, 1 = falling, 2 = any.
- PULSE_LEN, 16: high time of pulse bits in clk cycles, ≥1.
- OUT_RESET, 0: reset value of the output register.

- clk  in  1  system clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data; bits above the port width are ignored.
- readdata  out  32  combinational read data, zero-extended; read latency 0.
- in_port  in  IN_WIDTH  asynchronous input pins.
- out_port  out  OUT_WIDTH  output register.
- irq  out  1  level interrupt: |(edge_cap & irq_mask).

## Operation
- Register map (word address, read / write):
  - 0 DATA: reads data_out. A write replaces data_out, clears pulse_mask and stops the counter.
  - 1 IN: reads the synchronised input (sync2). Writes are ignored.
  - 2 IRQMASK: read/write, IN_WIDTH bits.
  - 3 EDGECAP: reads edge_cap. Writing a 1 to a bit clears that bit.
  - 4 OUTSET: reads 0. A write does data_out |= wd and pulse_mask &= ~wd, so those bits become permanently high.
  - 5 OUTCLR: reads 0. A write does data_out &= ~wd and pulse_mask &= ~wd.
  - 6 PULSE: reads pulse_mask. Writing a nonzero value does data_out |= wd and pulse_mask |= wd, and reloads the counter to PULSE_LEN. Writing zero has no effect.
  - 7: reads 0; writes are ignored.
- Pulse counter:
  - Width is $clog2(PULSE_LEN+1).
  - It decrements while nonzero.
  - When it is 1, the next edge applies data_out &= ~pulse_mask, clears pulse_mask and sets the counter to 0.
- Collision with expiry:
  - A DATA, OUTSET or OUTCLR write in the expiry cycle takes priority over the expiry clear for the bits it touches.
  - For the remaining pulse_mask bits, the expiry clear still applies.
  - A PULSE write in the expiry cycle reloads the counter. Old pulse bits merge into the new pulse and are not cleared.
- Edge detect:
  - Input path is sync1 <- in_port, sync2 <- sync1, prev <- sync2.
  - rise = sync2 & ~prev; fall = ~sync2 & prev; any = sync2 ^ prev.
  - edge_cap bits are sticky. A new edge and a write-1-clear on the same bit in the same cycle leave the bit set.
- Reset values:
  - data_out = OUT_RESET, so out_port = OUT_RESET.
  - sync1, sync2, prev, edge_cap, irq_mask, pulse_mask and counter are all 0.
  - irq = 0.
- Because prev resets to 0, inputs high at reset release give a rising/any edge 2 cycles later. This is intentional; software clears EDGECAP at init.
- Reset asserted mid-pulse aborts the pulse immediately; out_port returns to OUT_RESET.

## Timing
- A write accepted at edge e is visible on out_port and readdata after e. There are no wait states.
- Inputs:
  - in_port is sampled at e0; IN readback reflects it after e1.
  - edge_cap is set at e2; irq rises after e2 if the bit is unmasked.
- irq is combinational from registers. An EDGECAP clear or IRQMASK write at e drops irq after e.
- Pulse:
  - A PULSE write at e0 drives the bits high after e0 and low after e0+PULSE_LEN, i.e. high for exactly PULSE_LEN cycles.
  - A re-write at e0+k extends the pulse to end at e0+k+PULSE_LEN for all pulse bits.
- Input pulses shorter than one clk period may be missed; no capture guarantee is given for them.

## Test plan
- Reset, OUT_RESET=8'hA5:
  - out_port=8'hA5, irq=0, all readbacks 0 except DATA=0xA5.
  - Assert reset mid-pulse -> out_port returns to 8'hA5 immediately.
- Atomic bit control:
  - DATA=0x0F, then OUTSET 0x30 -> 0x3F.
  - Then OUTCLR 0x03 -> 0x3C.
  - Reads of addresses 4/5/7 return 0.
- Pulse, PULSE_LEN=16:
  - PULSE 0x80 at cycle 10 -> bit7 high for cycles 11..26, low at 27.
  - Re-write at cycle 20 -> falls at 37.
  - OUTSET 0x80 at cycle 15 -> bit7 stays high and PULSE reads 0.
- Expiry collision:
  - PULSE 0x03, then OUTSET 0x01 in the expiry cycle -> out bit0=1, bit1=0.
- Edge capture, EDGE_TYPE=0, IRQMASK=0x01:
  - in_port bit0 0->1 at e0 -> EDGECAP=0x01 and irq=1 after e2.
  - 1->0 -> no new capture.
  - EDGECAP write 0x01 -> irq=0.
  - Repeat with EDGE_TYPE=2: both edges capture.
- Clear/edge collision:
  - New edge on bit3 in the same cycle as an EDGECAP write of 0x08 -> bit3 remains set.
  - With bit3 unmasked, irq stays 1.
